// File: rtl/rc4_ksa.sv
// RC4 key-scheduling stage: fills S with the identity permutation,
// then shuffles it with the secret key over a shared single-port RAM.
module rc4_ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             s_q,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  output logic                   done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_SI,
    RD_SI_W,
    CALC_J,
    RD_SJ,
    RD_SJ_W,
    WR_SI,
    WR_SJ,
    DONE
  } state_t;

  state_t                 state;
  logic [7:0]             i;
  logic [7:0]             j;
  logic [7:0]             si;
  logic [7:0]             sj;
  logic [KW-1:0]          key_idx;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             kbyte;

  // Select the current key byte; byte 0 is the most significant.
  always_comb begin
    kbyte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (key_idx == KW'(n)) begin
        kbyte = key_q[8*(KEY_BYTES-n)-1 -: 8];
      end
    end
  end

  // Sequencer: init sweep, then 7-cycle read/read/swap per index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      key_idx <= '0;
      key_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            key_q <= secret_key;
            i     <= '0;
            state <= INIT;
          end
        end
        INIT: begin
          if (i == 8'hFF) begin
            i       <= '0;
            j       <= '0;
            key_idx <= '0;
            state   <= RD_SI;
          end else begin
            i <= i + 8'd1;
          end
        end
        RD_SI: state <= RD_SI_W;
        RD_SI_W: begin
          si    <= s_q;
          state <= CALC_J;
        end
        CALC_J: begin
          j     <= j + si + kbyte;
          state <= RD_SJ;
        end
        RD_SJ: state <= RD_SJ_W;
        RD_SJ_W: begin
          sj    <= s_q;
          state <= WR_SI;
        end
        WR_SI: state <= WR_SJ;
        WR_SJ: begin
          if (i == 8'hFF) begin
            state <= DONE;
          end else begin
            i <= i + 8'd1;
            if (key_idx == KW'(KEY_BYTES-1)) begin
              key_idx <= '0;
            end else begin
              key_idx <= key_idx + KW'(1);
            end
            state <= RD_SI;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port and done decode straight from state and registers.
  always_comb begin
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    done      = 1'b0;
    unique case (state)
      INIT: begin
        s_address = i;
        s_data    = i;
        s_wren    = 1'b1;
      end
      RD_SI, RD_SI_W: s_address = i;
      RD_SJ, RD_SJ_W: s_address = j;
      WR_SI: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
      end
      WR_SJ: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa.sv
// Bench for rc4_ksa: 3-byte and 1-byte key instances, each with a
// behavioural S RAM, checked against a plain RC4 KSA reference.
module tb_rc4_ksa;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [23:0] key0 = '0;
  logic [7:0]  key1 = '0;
  logic [7:0]  q0, q1, a0, a1, d0, d1;
  logic        w0, w1, done0, done1;

  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  logic [7:0]  exp_s [256];
  logic [15:0] wlog [$];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0] key;
    logic [47:0] addr;
    logic [47:0] data;
  } vec_t;

  vec_t tbl [2];

  always #5 clock = ~clock;

  rc4_ksa #(.KEY_BYTES(3)) dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .secret_key(key0), .s_q(q0), .s_address(a0),
    .s_data(d0), .s_wren(w0), .done(done0)
  );

  rc4_ksa #(.KEY_BYTES(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .secret_key(key1), .s_q(q1), .s_address(a1),
    .s_data(d1), .s_wren(w1), .done(done1)
  );

  always @(posedge clock) begin
    if (w0) mem0[a0] <= d0;
    q0 <= mem0[a0];
    if (w1) mem1[a1] <= d1;
    q1 <= mem1[a1];
  end

  always @(negedge clock) begin
    if (w0) wlog.push_back({a0, d0});
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic model(input logic [23:0] key, input int nb);
    int jj;
    logic [7:0] t, kb;
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    jj = 0;
    for (int k = 0; k < 256; k++) begin
      kb = 8'(key >> (8 * (nb - 1 - (k % nb))));
      jj = (jj + int'(exp_s[k]) + int'(kb)) % 256;
      t = exp_s[k];
      exp_s[k] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic run(input bit sel, input logic [23:0] key);
    int n;
    int distinct;
    bit dn;
    bit seen [256];
    logic [7:0] v;
    @(negedge clock);
    wlog.delete();
    if (sel) begin
      key1 = key[7:0];
      start1 = 1'b1;
    end else begin
      key0 = key;
      start0 = 1'b1;
    end
    n = 0;
    dn = 1'b0;
    while (!dn && n < 3000) begin
      @(posedge clock);
      n++;
      #1;
      dn = sel ? done1 : done0;
    end
    chk("latency", n, 2049);
    model(key, sel ? 1 : 3);
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    distinct = 0;
    for (int k = 0; k < 256; k++) begin
      v = sel ? mem1[k] : mem0[k];
      chk("s_byte", int'(v), int'(exp_s[k]));
      if (!seen[v]) distinct++;
      seen[v] = 1'b1;
    end
    chk("perm", distinct, 256);
  endtask

  task automatic hold_and_drop(input bit sel);
    int nwr;
    int nlow;
    nwr = 0;
    nlow = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (sel ? w1 : w0) nwr++;
      if (!(sel ? done1 : done0)) nlow++;
    end
    chk("hold_wr", nwr, 0);
    chk("hold_done", nlow, 0);
    if (sel) start1 = 1'b0;
    else start0 = 1'b0;
    @(posedge clock);
    #1;
    chk("drop_done", int'(sel ? done1 : done0), 0);
  endtask

  initial begin
    tbl[0] = '{24'h000000,
               {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3},
               {8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2}};
    tbl[1] = '{24'h00033C,
               {8'd0, 8'd0, 8'd1, 8'd4, 8'd2, 8'd66},
               {8'd0, 8'd0, 8'd4, 8'd1, 8'd66, 8'd2}};

    #1;
    chk("rst_wren0", int'(w0), 0);
    chk("rst_addr0", int'(a0), 0);
    chk("rst_data0", int'(d0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_wren1", int'(w1), 0);
    chk("rst_done1", int'(done1), 0);
    #12 reset = 1'b1;

    for (int v = 0; v < 2; v++) begin
      run(1'b0, tbl[v].key);
      chk("wlog_size", wlog.size(), 768);
      if (wlog.size() >= 262) begin
        for (int k = 0; k < 256; k++) begin
          chk("init_wr", int'(wlog[k]), int'({8'(k), 8'(k)}));
        end
        for (int k = 0; k < 6; k++) begin
          chk("early_wr", int'(wlog[256+k]),
              int'({tbl[v].addr[47-8*k -: 8],
                    tbl[v].data[47-8*k -: 8]}));
        end
      end
      hold_and_drop(1'b0);
    end

    for (int r = 0; r < 2; r++) begin
      run(1'b0, 24'($urandom));
      hold_and_drop(1'b0);
    end

    run(1'b1, 24'h00005A);
    hold_and_drop(1'b1);
    for (int r = 0; r < 2; r++) begin
      run(1'b1, {16'h0, 8'($urandom)});
      hold_and_drop(1'b1);
    end

    @(negedge clock);
    key0 = 24'hABCDEF;
    start0 = 1'b1;
    repeat (101) @(posedge clock);
    #2;
    chk("mid_init_wren", int'(w0), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_wren", int'(w0), 0);
    chk("mid_rst_addr", int'(a0), 0);
    chk("mid_rst_data", int'(d0), 0);
    chk("mid_rst_done", int'(done0), 0);
    start0 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    begin
      int nwr;
      int nd;
      nwr = 0;
      nd = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clock);
        if (w0) nwr++;
        if (done0) nd++;
      end
      chk("idle_wr", nwr, 0);
      chk("idle_done", nd, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
